// File: rtl/stream_queue.sv
// stream_queue: single-clock show-ahead FIFO with level, watermark and
// sticky error reporting.
//
// Ports:
//   clk          sole clock, rising edge
//   rst          asynchronous, active-high reset
//   flush        synchronous clear of the queue contents
//   in_valid     producer offers in_data
//   in_data      enqueue payload
//   in_ready     queue can accept (level != DEPTH)
//   out_valid    out_data holds the head entry (level != 0)
//   out_data     head entry, zero when empty (show-ahead, unregistered)
//   out_ready    consumer takes the head entry
//   level        current occupancy 0..DEPTH
//   almost_full  level >= AF_LEVEL
//   almost_empty level <= AE_LEVEL
//   overflow     sticky: enqueue attempted while in_ready low
//   underflow    sticky: dequeue attempted while out_valid low
//   clr_err      synchronous clear of overflow/underflow
module stream_queue #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned DEPTH      = 256,
   parameter int unsigned AF_LEVEL   = DEPTH - 4,
   parameter int unsigned AE_LEVEL   = 4,
   localparam int unsigned AW        = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   input  logic                  out_ready,
   output logic [AW:0]           level,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic                  overflow,
   output logic                  underflow,
   input  logic                  clr_err
);

   localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0] LVL_AF   = (AW+1)'(AF_LEVEL);
   localparam logic [AW:0] LVL_AE   = (AW+1)'(AE_LEVEL);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         head;
   logic [AW-1:0]         tail;
   logic [AW:0]           level_q;
   logic                  enq;
   logic                  deq;

   // Handshake and status decode, all from registered state only.
   assign in_ready     = (level_q != LVL_FULL);
   assign out_valid    = (level_q != '0);
   assign level        = level_q;
   assign almost_full  = (level_q >= LVL_AF);
   assign almost_empty = (level_q <= LVL_AE);
   assign enq          = in_valid && in_ready;
   assign deq          = out_valid && out_ready;

   // Show-ahead read; zero when empty so stale memory never leaks out.
   assign out_data = out_valid ? mem[head] : '0;

   // Storage array is deliberately not reset; flush/reset discard writes.
   always_ff @(posedge clk) begin
      if (!rst && enq && !flush) begin
         mem[tail] <= in_data;
      end
   end

   // Pointers, occupancy and sticky error flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head      <= '0;
         tail      <= '0;
         level_q   <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (flush) begin
            head    <= '0;
            tail    <= '0;
            level_q <= '0;
         end else begin
            if (enq) begin
               tail <= tail + AW'(1);
            end
            if (deq) begin
               head <= head + AW'(1);
            end
            if (enq && !deq) begin
               level_q <= level_q + (AW+1)'(1);
            end else if (deq && !enq) begin
               level_q <= level_q - (AW+1)'(1);
            end
         end

         // A new error event takes priority over a same-cycle clear.
         if (in_valid && !in_ready) begin
            overflow <= 1'b1;
         end else if (clr_err) begin
            overflow <= 1'b0;
         end

         if (out_ready && !out_valid) begin
            underflow <= 1'b1;
         end else if (clr_err) begin
            underflow <= 1'b0;
         end
      end
   end

endmodule
